ram_param_init: RTL

Parametrised single-port synchronous RAM for the image compressor/decompressor datapath. It replaces the fixed 24-bit × 4096 RAM and adds:
- configurable width, depth and read latency;
- per-lane write masking;
- an explicit read handshake with a valid flag;
- a hardware init sequencer that fills the array with a known value after reset or on request.

It sits between the codec control FSMs and the pixel/coefficient buffers.

---
 rtl/ram_param_init.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ram_param_init.sv
// ram_param_init
// Parametrised single-port synchronous RAM with per-lane write masking,
// a registered read pipeline (latency 1 or 2) with a valid strobe, a
// tri-stated output hold register and a hardware init sequencer that fills
// the whole array with INIT_VAL after reset or on a CLR pulse.

module ram_param_init #(
    parameter int              DW       = 24,
    parameter int              AW       = 12,
    parameter int              NLANE    = 3,
    parameter int              LAT      = 1,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic              CK,
    input  logic              RST_N,
    input  logic [AW-1:0]     A,
    input  logic              WE,
    input  logic [NLANE-1:0]  BE,
    input  logic [DW-1:0]     D,
    input  logic              RE,
    input  logic              CLR,
    input  logic              OE,
    output logic [DW-1:0]     Q,
    output logic              RVALID,
    output logic              BUSY
);

    localparam int LW = DW / NLANE;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Bad parameter combinations stop elaboration outright.
    if (LAT != 1 && LAT != 2) begin : g_bad_lat
        $error("ram_param_init: LAT must be 1 or 2");
    end
    if ((DW % NLANE) != 0) begin : g_bad_lane
        $error("ram_param_init: DW must be divisible by NLANE");
    end

    logic [0:0]    state;
    logic [AW-1:0] init_cnt;
    logic [DW-1:0] mem [0:(2**AW)-1];
    logic          run_we;
    logic          run_re;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] hold;
    logic          rvalid;

    // A CLR pulse in RUN swallows any request presented alongside it.
    assign run_we = (state == ST_RUN) && WE && !CLR;
    assign run_re = (state == ST_RUN) && RE && !CLR;

    // Write-first read word: enabled lanes take the incoming data, the rest the stored word.
    always_comb begin
        rd_word = mem[A];
        for (int i = 0; i < NLANE; i++) begin
            if (run_we && BE[i]) begin
                rd_word[i*LW +: LW] = D[i*LW +: LW];
            end
        end
    end

    // Two-state controller: INIT walks the counter to the top address, CLR sends RUN back to INIT.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + AW'(1);
            if (init_cnt == {AW{1'b1}}) begin
                state <= ST_RUN;
            end
        end else if (CLR) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end
    end

    // Array update: full-word fill during INIT, lane-masked writes during RUN.
    always_ff @(posedge CK) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= INIT_VAL;
        end else if (run_we) begin
            for (int i = 0; i < NLANE; i++) begin
                if (BE[i]) begin
                    mem[A][i*LW +: LW] <= D[i*LW +: LW];
                end
            end
        end
    end

    if (LAT == 2) begin : g_lat2
        logic [DW-1:0] stage;
        logic          stage_v;

        // Two-stage read pipeline; data already in the stage drains even if CLR arrives.
        always_ff @(posedge CK or negedge RST_N) begin
            if (!RST_N) begin
                stage   <= '0;
                stage_v <= 1'b0;
                hold    <= '0;
                rvalid  <= 1'b0;
            end else begin
                stage_v <= run_re;
                if (run_re) begin
                    stage <= rd_word;
                end
                rvalid <= stage_v;
                if (stage_v) begin
                    hold <= stage;
                end
            end
        end
    end else begin : g_lat1
        // Single-stage read: the sampled word lands straight in the hold register.
        always_ff @(posedge CK or negedge RST_N) begin
            if (!RST_N) begin
                hold   <= '0;
                rvalid <= 1'b0;
            end else begin
                rvalid <= run_re;
                if (run_re) begin
                    hold <= rd_word;
                end
            end
        end
    end

    assign RVALID = rvalid;
    assign BUSY   = (state == ST_INIT);
    assign Q      = OE ? hold : {DW{1'bz}};

endmodule
